// File: rtl/divu_unit.sv
// divu_unit: multi-cycle unsigned divider sitting beside the EX-stage ALU.
// A DIVU function code starts a 32-step restoring division. The quotient goes
// to LO and the remainder to HI. The unit holds the pipeline while it works.
//
// state | meaning
// IDLE  | waiting for a DIVU; a start latches the operands
// RUN   | one restoring iteration per clock, dividend MSB first
// DONE  | result written to hi/lo; done and busy are high for this one cycle
module divu_unit #(
  parameter int         WIDTH     = 32,
  parameter logic [5:0] DIVU_CODE = 6'b011011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, done_q;

  logic             start_accept;
  logic             last_iter;
  logic [WIDTH-1:0] src_rem, src_quo, src_div;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign start_accept = valid & (signal == DIVU_CODE) & (state_q == S_IDLE) & ~flush;
  assign last_iter    = (cnt_q == CW'(WIDTH - 1));

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // One restoring step. The first step is taken straight from the operands on
  // the accept edge, so the 32nd step lands on the edge before the done cycle.
  // Since rem < divisor, trial lies in [-divisor, divisor-1] and the WIDTH+1
  // bit two's-complement result carries a valid sign bit.
  always_comb begin
    src_rem  = (state_q == S_IDLE) ? '0    : rem_q;
    src_quo  = (state_q == S_IDLE) ? dataA : quo_q;
    src_div  = (state_q == S_IDLE) ? dataB : div_q;
    shifted  = {src_rem, src_quo[WIDTH-1]};
    trial    = shifted - {1'b0, src_div};
    trial_ok = ~trial[WIDTH];
    step_rem = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {src_quo[WIDTH-2:0], trial_ok};
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Next-state selection; flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          state_d = (dataB == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Stall output and datapath updates; hi/lo move only on entry to DONE
  always_comb begin
    stall = start_accept | busy_q;
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          div_d = dataB;
          if (dataB == '0) begin
            rem_d = '0;
            quo_d = '0;
            cnt_d = '0;
            hi_d  = dataA;
            lo_d  = '1;
          end else begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = CW'(1);
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          rem_d = '0;
          quo_d = '0;
          cnt_d = '0;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          if (last_iter) begin
            hi_d = step_rem;
            lo_d = step_quo;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule
